arbiter: RTL and testbench



---
 rtl/arbiter.sv | 102 ++++++++++
 tb/tb_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter.sv
//------------------------------------------------------------------------------
// Module   : arbiter
// Brief    : Two-requester registered grant arbiter (Moore FSM) with priority,
//            tie round-robin and a MAX_HOLD fairness limit.
//            Optional preemption by strictly higher priority: ARBITER_PREEMPT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ra,
  input  logic       rb,
  input  logic [1:0] PA,
  input  logic [1:0] PB,
  output logic       ga,
  output logic       gb
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam int            CW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CW'(MAX_HOLD - 1) : '0;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            r_last_b;   // 1: B held the most recent grant
  logic            w_hold_hit;
  logic            w_pre_a;    // A preempted by B
  logic            w_pre_b;    // B preempted by A

  always_comb begin
    w_hold_hit = (MAX_HOLD > 0) && (r_cnt == HOLD_LAST);
`ifdef ARBITER_PREEMPT_EN
    w_pre_a = (PB > PA);
    w_pre_b = (PA > PB);
`else
    w_pre_a = 1'b0;
    w_pre_b = 1'b0;
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (ra && !rb)      w_next = GNT_A;
        else if (rb && !ra) w_next = GNT_B;
        else if (ra && rb) begin
          if (PA > PB)      w_next = GNT_A;
          else if (PB > PA) w_next = GNT_B;
          else              w_next = r_last_b ? GNT_A : GNT_B;
        end
      end
      GNT_A: begin
        if (!ra)                             w_next = rb ? GNT_B : IDLE;
        else if (rb && (w_hold_hit || w_pre_a)) w_next = GNT_B;
      end
      GNT_B: begin
        if (!rb)                             w_next = ra ? GNT_A : IDLE;
        else if (ra && (w_hold_hit || w_pre_b)) w_next = GNT_A;
      end
      default: w_next = IDLE;
    endcase
  end

  // Counts cycles the current owner keeps the grant while the other side waits.
  always_comb begin
    w_cnt_next = '0;
    if ((MAX_HOLD > 0) && (w_next == r_state) &&
        (((r_state == GNT_A) && rb) || ((r_state == GNT_B) && ra)))
      w_cnt_next = r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_last_b <= 1'b1;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_next == GNT_A)      r_last_b <= 1'b0;
      else if (w_next == GNT_B) r_last_b <= 1'b1;
    end
  end

  assign ga = (r_state == GNT_A);
  assign gb = (r_state == GNT_B);

endmodule

`default_nettype wire

// File: tb/tb_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_arbiter
// Brief    : Self-checking bench for arbiter against a behavioural owner model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ra, rb;
  logic [1:0] pa, pb;
  logic       ga, gb;

  int tests = 0;
  int fails = 0;

  // Model: owner 0 = nobody, 1 = A, 2 = B
  int m_owner;
  int m_last;
  int m_streak;

  always #5 clk = ~clk;

  arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .ra(ra), .rb(rb),
    .PA(pa), .PB(pb), .ga(ga), .gb(gb)
  );

  task automatic model_reset();
    m_owner  = 0;
    m_last   = 2;
    m_streak = 0;
  endtask

  task automatic model_step(input logic a, input logic b, input int p_a, input int p_b);
    int nxt, me_req, ot_req, me_p, ot_p, other, streak;
    nxt    = m_owner;
    streak = 0;
    if (m_owner == 0) begin
      if (a && !b)      nxt = 1;
      else if (b && !a) nxt = 2;
      else if (a && b)  nxt = (p_a > p_b) ? 1 : (p_b > p_a) ? 2 : (m_last == 1 ? 2 : 1);
    end else begin
      me_req = (m_owner == 1) ? int'(a) : int'(b);
      ot_req = (m_owner == 1) ? int'(b) : int'(a);
      me_p   = (m_owner == 1) ? p_a : p_b;
      ot_p   = (m_owner == 1) ? p_b : p_a;
      other  = 3 - m_owner;
      if (me_req == 0) begin
        nxt = (ot_req != 0) ? other : 0;
      end else if (ot_req != 0) begin
        streak = m_streak + 1;
        if (MAX_HOLD > 0 && streak == MAX_HOLD) nxt = other;
`ifdef ARBITER_PREEMPT_EN
        if (ot_p > me_p) nxt = other;
`endif
      end
    end
    m_streak = (nxt == m_owner && nxt != 0) ? streak : 0;
    if (nxt != 0) m_last = nxt;
    m_owner = nxt;
  endtask

  function automatic logic [1:0] model_grants();
    return {m_owner == 1, m_owner == 2};
  endfunction

  task automatic cycle(input logic a, input logic b, input logic [1:0] p_a, input logic [1:0] p_b);
    @(negedge clk);
    ra = a; rb = b; pa = p_a; pb = p_b;
    model_step(a, b, int'(p_a), int'(p_b));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    ra = 0; rb = 0; pa = 0; pb = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #4;
    tests++;
    if ({ga, gb} !== 2'b00) begin
      fails++; $display("FAIL reset_during: got %b want 00", {ga, gb});
    end
    #4 rst = 1'b0;
    #2;
    tests++;
    if ({ga, gb} !== 2'b00) begin
      fails++; $display("FAIL reset_release: got %b want 00 at %0t", {ga, gb}, $time);
    end
  endtask

  task automatic test_single();
    logic [1:0] exp [5] = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b10};
    logic       sa  [5] = '{1, 0, 0, 1, 1};
    logic       sb  [5] = '{0, 0, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(sa[i], sb[i], 2'd0, 2'd0);
      tests++;
      if ({ga, gb} !== exp[i] || model_grants() !== exp[i]) begin
        fails++; $display("FAIL single[%0d]: got %b want %b", i, {ga, gb}, exp[i]);
      end
    end
  endtask

  task automatic test_priority();
    do_reset();
    cycle(1, 1, 2'd2, 2'd1);
    tests++;
    if ({ga, gb} !== 2'b10) begin
      fails++; $display("FAIL prio_a: got %b want 10", {ga, gb});
    end
    cycle(0, 0, 2'd0, 2'd0);
    cycle(1, 1, 2'd1, 2'd3);
    tests++;
    if ({ga, gb} !== 2'b01) begin
      fails++; $display("FAIL prio_b: got %b want 01", {ga, gb});
    end
    cycle(0, 0, 2'd0, 2'd0);
  endtask

  task automatic test_tie();
    do_reset();
    cycle(1, 1, 2'd2, 2'd2);
    tests++;
    if ({ga, gb} !== 2'b10) begin
      fails++; $display("FAIL tie_first: got %b want 10", {ga, gb});
    end
    cycle(0, 0, 2'd2, 2'd2);
    tests++;
    if ({ga, gb} !== 2'b00) begin
      fails++; $display("FAIL tie_idle: got %b want 00", {ga, gb});
    end
    cycle(1, 1, 2'd2, 2'd2);
    tests++;
    if ({ga, gb} !== 2'b01) begin
      fails++; $display("FAIL tie_second: got %b want 01", {ga, gb});
    end
  endtask

  task automatic test_hold();
    int n;
    do_reset();
    cycle(1, 1, 2'd3, 2'd0);
    n = 0;
    while (ga === 1'b1 && n < 20) begin
      n++;
      cycle(1, 1, 2'd3, 2'd0);
    end
    tests++;
    if (n != MAX_HOLD || gb !== 1'b1) begin
      fails++; $display("FAIL hold_limit: ga cycles %0d gb %b want %0d and 1", n, gb, MAX_HOLD);
    end
  endtask

  task automatic test_preempt();
    logic [1:0] exp;
`ifdef ARBITER_PREEMPT_EN
    exp = 2'b01;
`else
    exp = 2'b10;
`endif
    do_reset();
    cycle(1, 0, 2'd1, 2'd0);
    cycle(1, 1, 2'd1, 2'd3);
    tests++;
    if ({ga, gb} !== exp) begin
      fails++; $display("FAIL preempt: got %b want %b", {ga, gb}, exp);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(1, 0, 2'd0, 2'd0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({ga, gb} !== 2'b00) begin
      fails++; $display("FAIL reset_mid: got %b want 00", {ga, gb});
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int errs = 0;
    logic a, b;
    logic [1:0] p_a, p_b;
    do_reset();
    p_a = 0; p_b = 0;
    for (int i = 0; i < 600; i++) begin
      a = ($urandom_range(0, 5) != 0);
      b = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 7) == 0) p_a = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) p_b = 2'($urandom_range(0, 3));
      cycle(a, b, p_a, p_b);
      tests++;
      if ({ga, gb} !== model_grants() || (ga & gb) !== 1'b0) begin
        fails++; errs++;
        if (errs < 10) $display("FAIL random[%0d]: got %b want %b", i, {ga, gb}, model_grants());
      end
    end
  endtask

  initial begin
    rst = 1'b1; ra = 0; rb = 0; pa = 0; pb = 0;
    model_reset();
    test_reset();
    test_single();
    test_priority();
    test_tie();
    test_hold();
    test_preempt();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
